// File: rtl/ahb_sram_slave_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : ahb_sram_slave_pkg
//  Description : Shared AHB-Lite bus types: transfer size, kind, response,
//                burst and protection encodings plus bus word geometry.
//  Revision    : 1.0 - initial release
// ============================================================================
package ahb_sram_slave_pkg;

    localparam int WORD_BYTES = 4;

    typedef enum logic [2:0] {
        SIZE_BYTE   = 3'd0,
        SIZE_HALF   = 3'd1,
        SIZE_WORD   = 3'd2,
        SIZE_DWORD  = 3'd3,
        SIZE_QWORD  = 3'd4,
        SIZE_8WORD  = 3'd5,
        SIZE_16WORD = 3'd6,
        SIZE_32WORD = 3'd7
    } transfer_size;

    typedef enum logic [1:0] {
        TRANS_IDLE   = 2'd0,
        TRANS_BUSY   = 2'd1,
        TRANS_NONSEQ = 2'd2,
        TRANS_SEQ    = 2'd3
    } transfer_kind;

    typedef enum logic {
        RESP_OKAY  = 1'b0,
        RESP_ERROR = 1'b1
    } transfer_response;

    typedef enum logic [2:0] {
        BURST_SINGLE = 3'd0,
        BURST_INCR   = 3'd1,
        BURST_WRAP4  = 3'd2,
        BURST_INCR4  = 3'd3,
        BURST_WRAP8  = 3'd4,
        BURST_INCR8  = 3'd5,
        BURST_WRAP16 = 3'd6,
        BURST_INCR16 = 3'd7
    } transfer_burst;

    typedef enum logic [3:0] {
        PROT_OPCODE_USER = 4'd0,
        PROT_DATA_USER   = 4'd1,
        PROT_OPCODE_PRIV = 4'd2,
        PROT_DATA_PRIV   = 4'd3
    } transfer_protection;

endpackage
`default_nettype wire

// File: rtl/ahb_lane_decode.sv
`default_nettype none
// ============================================================================
//  Module      : ahb_lane_decode
//  Description : Byte-lane enables for a 32-bit AHB data bus from transfer
//                size and low address bits; flags misaligned or oversized
//                transfers.
//  Revision    : 1.0 - initial release
// ============================================================================
module ahb_lane_decode
    import ahb_sram_slave_pkg::*;
(
    input  transfer_size size,
    input  logic [1:0]   addr_lo,
    output logic [3:0]   lanes,
    output logic         misaligned
);

    // Sizes wider than a word cannot be served on this bus, so they are flagged too
    always_comb begin
        lanes      = 4'b0000;
        misaligned = 1'b0;
        case (size)
            SIZE_BYTE: lanes = 4'b0001 << addr_lo;
            SIZE_HALF: begin
                lanes      = addr_lo[1] ? 4'b1100 : 4'b0011;
                misaligned = addr_lo[0];
            end
            SIZE_WORD: begin
                lanes      = 4'b1111;
                misaligned = |addr_lo;
            end
            default:   misaligned = 1'b1;
        endcase
    end

endmodule
`default_nettype wire

// File: rtl/ahb_sram_slave.sv
`default_nettype none
// ============================================================================
//  Module      : ahb_sram_slave
//  Description : AHB-Lite subordinate backed by word-organised register
//                memory, with byte-lane writes, programmable wait states and
//                the two-cycle ERROR response.
//  Revision    : 1.0 - initial release
// ============================================================================
module ahb_sram_slave
    import ahb_sram_slave_pkg::*;
#(
    parameter int DEPTH_WORDS = 512,
    parameter int WAIT_STATES = 0,
    parameter int ADDR_BITS   = 11
) (
    input  logic               clock,
    input  logic               nreset,
    input  logic               sel,
    input  logic               write,
    input  logic [31:0]        addr,
    input  transfer_size       size,
    input  transfer_kind       trans,
    input  transfer_burst      burst,
    input  transfer_protection prot,
    input  logic               mastlock,
    input  logic               ready_in,
    input  logic [31:0]        wdata,
    output logic [31:0]        rdata,
    output logic               ready_out,
    output transfer_response   resp
);

    localparam logic [1:0]  ST_IDLE     = 2'd0;
    localparam logic [1:0]  ST_DATA     = 2'd1;
    localparam logic [1:0]  ST_ERR1     = 2'd2;
    localparam logic [1:0]  ST_ERR2     = 2'd3;
    localparam int          IDX_W       = $clog2(DEPTH_WORDS);
    localparam logic [3:0]  WAIT_LIMIT  = 4'(WAIT_STATES);
    localparam logic [31:0] DEPTH_LIMIT = 32'(DEPTH_WORDS);

    logic [1:0]           r_state;
    logic [3:0]           r_wait_cnt;
    logic [ADDR_BITS-1:0] r_addr;
    transfer_size         r_size;
    logic                 r_write;
    logic [31:0]          r_mem [DEPTH_WORDS];

    logic [3:0]           w_bus_lanes;
    logic                 w_bus_misaligned;
    logic [3:0]           w_lanes;
    logic                 w_cap_misaligned;
    logic [31:0]          w_word_index;
    logic                 w_out_of_range;
    logic                 w_accept;
    logic                 w_done;
    logic [IDX_W-1:0]     w_idx;
    logic                 w_unused;

    // Alignment check on the address phase currently on the bus
    ahb_lane_decode u_bus_decode (
        .size       (size),
        .addr_lo    (addr[1:0]),
        .lanes      (w_bus_lanes),
        .misaligned (w_bus_misaligned)
    );

    // Lane enables for the captured transfer, used at write commit
    ahb_lane_decode u_cap_decode (
        .size       (r_size),
        .addr_lo    (r_addr[1:0]),
        .lanes      (w_lanes),
        .misaligned (w_cap_misaligned)
    );

    assign w_word_index   = 32'(addr[ADDR_BITS-1:2]);
    assign w_out_of_range = (w_word_index >= DEPTH_LIMIT);
    assign w_done         = (r_wait_cnt == WAIT_LIMIT);
    // Only in-range transfers reach DATA, so the truncated index is exact there
    assign w_idx          = r_addr[IDX_W+1:2];
    // ready_out already encodes "idle or completing", which is when a new
    // address phase may be sampled
    assign w_accept       = sel && ready_in && ready_out
                            && (trans == TRANS_NONSEQ || trans == TRANS_SEQ);
    assign w_unused       = ^{burst, prot, mastlock, addr, r_addr,
                              w_bus_lanes, w_cap_misaligned};

    // Transfer state, wait counter and captured address-phase control
    always_ff @(posedge clock or negedge nreset) begin
        if (!nreset) begin
            r_state    <= ST_IDLE;
            r_wait_cnt <= 4'd0;
            r_addr     <= '0;
            r_size     <= SIZE_BYTE;
            r_write    <= 1'b0;
        end else if (w_accept) begin
            r_state    <= (w_bus_misaligned || w_out_of_range) ? ST_ERR1 : ST_DATA;
            r_wait_cnt <= 4'd0;
            r_addr     <= addr[ADDR_BITS-1:0];
            r_size     <= size;
            r_write    <= write;
        end else begin
            case (r_state)
                ST_DATA: begin
                    if (w_done) begin
                        r_state    <= ST_IDLE;
                        r_wait_cnt <= 4'd0;
                    end else begin
                        r_wait_cnt <= r_wait_cnt + 4'd1;
                    end
                end
                ST_ERR1: r_state <= ST_ERR2;
                default: r_state <= ST_IDLE;
            endcase
        end
    end

    // Commit lane-aligned write data on the completing edge of a write data phase
    always_ff @(posedge clock) begin
        if (r_state == ST_DATA && w_done && r_write) begin
            for (int b = 0; b < WORD_BYTES; b++) begin
                if (w_lanes[b]) begin
                    r_mem[w_idx][8*b +: 8] <= wdata[8*b +: 8];
                end
            end
        end
    end

    // Bus response and read data decoded from the transfer state
    always_comb begin
        ready_out = 1'b1;
        resp      = RESP_OKAY;
        rdata     = 32'h0;
        case (r_state)
            ST_DATA: begin
                ready_out = w_done;
                if (!r_write) begin
                    rdata = r_mem[w_idx];
                end
            end
            ST_ERR1: begin
                ready_out = 1'b0;
                resp      = RESP_ERROR;
            end
            ST_ERR2: resp = RESP_ERROR;
            default: ;
        endcase
    end

endmodule
`default_nettype wire

// File: tb/tb_ahb_sram_slave.sv
`default_nettype none
// ============================================================================
//  Module      : tb_ahb_sram_slave
//  Description : Scoreboard bench for ahb_sram_slave; three instances with
//                0, 3 and 2 wait states share one pipelined AHB master.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_ahb_sram_slave;
    import ahb_sram_slave_pkg::*;

    typedef struct {
        bit          wr;
        logic [31:0] a;
        logic [2:0]  sz;
        logic [1:0]  kind;
        bit          selx;
        logic [31:0] wd;
        logic [31:0] ed;
        bit          eerr;
    } xfer_t;

    logic             clock = 1'b0;
    logic             nreset;
    logic [2:0]       sel_v;
    logic             write;
    logic [31:0]      addr;
    transfer_size     size;
    transfer_kind     trans;
    logic             ready_in;
    logic [31:0]      wdata;
    logic [31:0]      rdata_v [3];
    logic             ready_v [3];
    transfer_response resp_v  [3];

    int    cur          = 0;
    int    tests_run    = 0;
    int    tests_failed = 0;
    int    waits_of [3] = '{0, 3, 2};
    xfer_t req_q [$];
    xfer_t exp_q [$];

    always #5 clock = ~clock;

    // The bus-wide ready follows whichever subordinate the master is talking to
    assign ready_in = ready_v[cur];

    ahb_sram_slave #(.DEPTH_WORDS(512), .WAIT_STATES(0), .ADDR_BITS(12)) u_dut0 (
        .clock(clock), .nreset(nreset), .sel(sel_v[0]), .write(write), .addr(addr),
        .size(size), .trans(trans), .burst(BURST_SINGLE), .prot(PROT_DATA_PRIV),
        .mastlock(1'b0), .ready_in(ready_in), .wdata(wdata),
        .rdata(rdata_v[0]), .ready_out(ready_v[0]), .resp(resp_v[0]));

    ahb_sram_slave #(.DEPTH_WORDS(512), .WAIT_STATES(3), .ADDR_BITS(12)) u_dut3 (
        .clock(clock), .nreset(nreset), .sel(sel_v[1]), .write(write), .addr(addr),
        .size(size), .trans(trans), .burst(BURST_INCR), .prot(PROT_DATA_USER),
        .mastlock(1'b0), .ready_in(ready_in), .wdata(wdata),
        .rdata(rdata_v[1]), .ready_out(ready_v[1]), .resp(resp_v[1]));

    ahb_sram_slave #(.DEPTH_WORDS(512), .WAIT_STATES(2), .ADDR_BITS(12)) u_dut2 (
        .clock(clock), .nreset(nreset), .sel(sel_v[2]), .write(write), .addr(addr),
        .size(size), .trans(trans), .burst(BURST_SINGLE), .prot(PROT_OPCODE_USER),
        .mastlock(1'b0), .ready_in(ready_in), .wdata(wdata),
        .rdata(rdata_v[2]), .ready_out(ready_v[2]), .resp(resp_v[2]));

    function automatic void add(bit wr, logic [31:0] a, logic [2:0] sz,
                                logic [31:0] wd, logic [31:0] ed, bit eerr);
        xfer_t x;
        x.wr = wr; x.a = a; x.sz = sz; x.kind = 2'd2; x.selx = 1'b1;
        x.wd = wd; x.ed = ed; x.eerr = eerr;
        req_q.push_back(x);
    endfunction

    function automatic void add_noop(logic [1:0] kind, bit selx, logic [31:0] a);
        xfer_t x;
        x.wr = 1'b1; x.a = a; x.sz = 3'd2; x.kind = kind; x.selx = selx;
        x.wd = 32'hFFFF_FFFF; x.ed = 32'h0; x.eerr = 1'b0;
        req_q.push_back(x);
    endfunction

    task automatic drive_idle();
        sel_v = 3'b000; trans = TRANS_IDLE; write = 1'b0;
        addr = 32'h0; size = SIZE_BYTE;
    endtask

    // Pipelined master: drives queued address phases, scores each data phase
    task automatic run_seq(string tag);
        bit               dp     = 1'b0;
        bit               hd;
        bit               r;
        transfer_response rs;
        logic [31:0]      rd;
        xfer_t            d;
        xfer_t            e;
        int               waits  = 0;
        int               ew;
        int               cycles = 0;
        @(posedge clock); #1;
        while ((req_q.size() > 0 || dp) && cycles < 200) begin
            cycles++;
            hd = (req_q.size() > 0);
            drive_idle();
            if (hd) begin
                sel_v[cur] = req_q[0].selx;
                trans      = transfer_kind'(req_q[0].kind);
                write      = req_q[0].wr;
                addr       = req_q[0].a;
                size       = transfer_size'(req_q[0].sz);
            end
            wdata = dp ? d.wd : 32'h0;
            @(negedge clock);
            r  = ready_v[cur];
            rs = resp_v[cur];
            rd = rdata_v[cur];
            if (dp) begin
                tests_run++;
                if (rs !== (d.eerr ? RESP_ERROR : RESP_OKAY)) begin
                    tests_failed++;
                    $display("FAIL %s resp @%h: got %0d want %0d", tag, d.a, rs, d.eerr);
                end
                if (!r) begin
                    waits++;
                end else begin
                    e  = exp_q.pop_front();
                    ew = e.eerr ? 1 : waits_of[cur];
                    tests_run++;
                    if (waits != ew) begin
                        tests_failed++;
                        $display("FAIL %s wait cycles @%h: got %0d want %0d", tag, e.a, waits, ew);
                    end
                    if (!e.wr && !e.eerr) begin
                        tests_run++;
                        if (rd !== e.ed) begin
                            tests_failed++;
                            $display("FAIL %s rdata @%h: got %h want %h", tag, e.a, rd, e.ed);
                        end
                    end
                    dp = 1'b0;
                end
            end else begin
                tests_run++;
                if (r !== 1'b1 || rs !== RESP_OKAY || rd !== 32'h0) begin
                    tests_failed++;
                    $display("FAIL %s idle: got ready=%b resp=%0d rdata=%h want 1/0/0", tag, r, rs, rd);
                end
            end
            @(posedge clock); #1;
            if (r && hd) begin
                d = req_q.pop_front();
                if (d.selx && d.kind[1]) begin
                    exp_q.push_back(d);
                    dp    = 1'b1;
                    waits = 0;
                end
            end
        end
        if (req_q.size() > 0 || dp) begin
            tests_run++;
            tests_failed++;
            $display("FAIL %s timeout: got %0d pending want 0", tag, req_q.size() + int'(dp));
            req_q.delete();
            exp_q.delete();
        end
        drive_idle();
    endtask

    task automatic test_reset();
        nreset = 1'b0;
        drive_idle();
        wdata = 32'h0;
        repeat (2) @(negedge clock);
        for (int k = 0; k < 3; k++) begin
            tests_run++;
            if (ready_v[k] !== 1'b1 || resp_v[k] !== RESP_OKAY || rdata_v[k] !== 32'h0) begin
                tests_failed++;
                $display("FAIL reset dut%0d: got %b/%0d/%h want 1/0/00000000",
                         k, ready_v[k], resp_v[k], rdata_v[k]);
            end
        end
        nreset = 1'b1;
    endtask

    task automatic test_back_to_back();
        cur = 0;
        add(1'b1, 32'h10, 3'd2, 32'hDEAD_BEEF, 32'h0, 1'b0);
        add(1'b0, 32'h10, 3'd2, 32'h0, 32'hDEAD_BEEF, 1'b0);
        run_seq("b2b");
    endtask

    task automatic test_byte_half();
        cur = 0;
        add(1'b1, 32'h10, 3'd2, 32'h1122_3344, 32'h0, 1'b0);
        add(1'b1, 32'h11, 3'd0, 32'h0000_AA00, 32'h0, 1'b0);
        add(1'b0, 32'h10, 3'd2, 32'h0, 32'h1122_AA44, 1'b0);
        add(1'b1, 32'h12, 3'd1, 32'hBEEF_0000, 32'h0, 1'b0);
        add(1'b0, 32'h10, 3'd2, 32'h0, 32'hBEEF_AA44, 1'b0);
        add(1'b1, 32'h13, 3'd0, 32'h7700_0000, 32'h0, 1'b0);
        add(1'b0, 32'h10, 3'd2, 32'h0, 32'h77EF_AA44, 1'b0);
        run_seq("lanes");
    endtask

    task automatic test_wait_states();
        cur = 1;
        add(1'b1, 32'h0, 3'd2, 32'h0BAD_F00D, 32'h0, 1'b0);
        add(1'b1, 32'h4, 3'd2, 32'h600D_CAFE, 32'h0, 1'b0);
        add(1'b0, 32'h0, 3'd2, 32'h0, 32'h0BAD_F00D, 1'b0);
        add(1'b0, 32'h4, 3'd2, 32'h0, 32'h600D_CAFE, 1'b0);
        run_seq("wait3");
    endtask

    task automatic test_errors();
        cur = 0;
        add(1'b1, 32'h0,   3'd2, 32'h5566_7788, 32'h0, 1'b0);
        add(1'b1, 32'h2,   3'd2, 32'hFFFF_FFFF, 32'h0, 1'b1);
        add(1'b0, 32'h800, 3'd2, 32'h0, 32'h0, 1'b1);
        add(1'b1, 32'h1,   3'd1, 32'hFFFF_FFFF, 32'h0, 1'b1);
        add(1'b1, 32'h0,   3'd3, 32'hFFFF_FFFF, 32'h0, 1'b1);
        add(1'b0, 32'h0,   3'd2, 32'h0, 32'h5566_7788, 1'b0);
        run_seq("err0");
        cur = 1;
        add(1'b1, 32'h2,   3'd2, 32'hFFFF_FFFF, 32'h0, 1'b1);
        add(1'b0, 32'h800, 3'd2, 32'h0, 32'h0, 1'b1);
        add(1'b0, 32'h0,   3'd2, 32'h0, 32'h0BAD_F00D, 1'b0);
        run_seq("err3");
    endtask

    task automatic test_no_transfer();
        cur = 0;
        add(1'b1, 32'h20, 3'd2, 32'h0102_0304, 32'h0, 1'b0);
        add_noop(2'd0, 1'b1, 32'h20);
        add_noop(2'd1, 1'b1, 32'h20);
        add_noop(2'd2, 1'b0, 32'h20);
        add(1'b0, 32'h20, 3'd2, 32'h0, 32'h0102_0304, 1'b0);
        run_seq("noxfer");
    endtask

    task automatic test_reset_mid_data();
        cur = 2;
        add(1'b1, 32'h14, 3'd2, 32'h1234_5678, 32'h0, 1'b0);
        run_seq("rst_pre");
        @(posedge clock); #1;
        sel_v[2] = 1'b1; trans = TRANS_NONSEQ; write = 1'b1;
        addr = 32'h14; size = SIZE_WORD;
        @(posedge clock); #1;
        drive_idle();
        wdata = 32'hCAFE_F00D;
        @(negedge clock);
        tests_run++;
        if (ready_v[2] !== 1'b0) begin
            tests_failed++;
            $display("FAIL rst_mid waiting ready: got %b want 0", ready_v[2]);
        end
        @(posedge clock); #2;
        nreset = 1'b0;
        #1;
        tests_run++;
        if (ready_v[2] !== 1'b1 || resp_v[2] !== RESP_OKAY || rdata_v[2] !== 32'h0) begin
            tests_failed++;
            $display("FAIL rst_mid outputs: got %b/%0d/%h want 1/0/00000000",
                     ready_v[2], resp_v[2], rdata_v[2]);
        end
        @(negedge clock);
        @(negedge clock);
        nreset = 1'b1;
        add(1'b0, 32'h14, 3'd2, 32'h0, 32'h1234_5678, 1'b0);
        run_seq("rst_post");
    endtask

    initial begin
        test_reset();
        test_back_to_back();
        test_byte_half();
        test_wait_states();
        test_errors();
        test_no_transfer();
        test_reset_mid_data();
        repeat (2) @(posedge clock);
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
`default_nettype wire
